imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Boot-time program loader that writes the instruction memory read by the fetch stage.
- Accepts a little-endian byte stream over a valid/ready handshake, typically from a UART receiver or testbench.
- Assembles 32-bit instruction words and writes them to consecutive word addresses starting at 0.
- Asserts done when loading is complete; done gates the core's fetch enable.

Parameters:
- ADDR_W, 6, word-address width of the instruction memory (capacity 2^ADDR_W words, default 64).

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  asynchronous active-high reset.
- in_valid  input  1  byte available on in_data.
- in_data  input  8  stream byte.
- in_ready  output  1  loader accepts a byte this cycle.
- we  output  1  one-cycle instruction-memory write strobe.
- waddr  output  ADDR_W  word address for the write.
- wdata  output  32  instruction word for the write.
- busy  output  1  load in progress (length received, not yet DONE/ERR).
- done  output  1  program loaded; held until reset; drives fetch enable.
- err  output  1  bad header or checksum; held until reset.

Behaviour:
- Reset (async, rst=1): state=LEN_LO, all outputs 0, word counter 0, byte lane 0, waddr 0.
- A byte is accepted on any posedge where in_valid && in_ready.
- in_ready=1 in states LEN_LO, LEN_HI, DATA and CSUM; 0 in DONE and ERR.
- No stalls: bytes may arrive back-to-back every cycle.
- Stream format:
  - 16-bit word count N, low byte first.
  - N*4 data bytes, each word least-significant byte first.
  - Optional checksum byte (see Optional Feature).
- LEN_LO: accept byte -> N[7:0]; go to LEN_HI.
- LEN_HI: accept byte -> N[15:8].
  - If N==0 or N>2^ADDR_W: go to ERR.
  - Else: go to DATA, busy=1.
- DATA: each accepted byte fills lane 0..3 of a 32-bit shift/assemble register.
  - On the 4th lane, in the next cycle: we=1, wdata=assembled word, waddr=current word index, then word index increments.
  - Latency: 4th byte accepted at edge t -> we high during cycle t+1.
- The write for the last word (index N-1) moves the state to CSUM (if enabled) or DONE in the same edge that raises we.
- DONE: busy=0. done=1 registered, rising in the cycle after the final we pulse, so the final write has completed before fetch starts.
- ERR: busy=0, err=1, done stays 0; no further writes.
- waddr holds its last value when we=0. wdata is don't-care when we=0 and is implemented as a held value.
- N == 2^ADDR_W: the final write is at address 2^ADDR_W-1; the word counter must not wrap before the completion check. Compare on a counter ADDR_W+1 bits wide.
- in_valid while in DONE/ERR: ignored, never accepted.
- rst asserted mid-load: immediate return to reset state. Partially written memory contents are not cleared; a fresh header is required.
- done and err are mutually exclusive.

Optional Feature:
- Macro: IMEM_LOADER_CHECKSUM_EN.
- Enabled:
  - After the last data byte, state CSUM accepts one byte.
  - If it equals the XOR of all 4N data bytes: go to DONE.
  - Else: go to ERR.
  - All N words have already been written regardless of the checksum outcome.
- Disabled: no CSUM state; the final write leads directly to DONE; no checksum logic is synthesized.

Test Plan:
- N=1, bytes 01 00 | 93 00 10 00, back-to-back -> one we pulse, waddr=0, wdata=32'h00100093; done=1 the cycle after we; in_ready=0 thereafter.
- N=3 with in_valid toggling 1/0 every cycle, words 11111111, 22222222, 33333333 -> we at waddr 0,1,2 with matching wdata; busy high from LEN_HI acceptance until done.
- Header 00 00 (N=0) -> err=1, no we, done=0. Header 41 00 (N=65, ADDR_W=6) -> err=1. Header 40 00 (N=64) -> 64 writes, last waddr=63, done=1.
- rst pulsed after 2 of 4 bytes of word 1 (N=2) -> outputs 0, in_ready=1. A new stream 01 00 AA BB CC DD -> we waddr=0, wdata=32'hDDCCBBAA.
- Checksum enabled, N=1 data 01 02 04 08: checksum 0F -> done=1; checksum 0E -> err=1, done=0, the single write still occurred.
- Bytes presented after done -> in_ready=0, no we, state unchanged.

Source files
------------

// File: rtl/imem_loader_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : imem_loader_if                                             |
// | Description : Byte-stream input and instruction-memory write bundle for  |
// |               the boot-time program loader.                              |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
interface imem_loader_if #(
    parameter int ADDR_W = 6
);
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [31:0]       wdata;
    logic              busy;
    logic              done;
    logic              err;

    modport master (
        output in_valid, in_data,
        input  in_ready, we, waddr, wdata, busy, done, err
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, we, waddr, wdata, busy, done, err
    );
endinterface
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : imem_loader                                                |
// | Description : Loads a length-prefixed little-endian byte stream into the |
// |               instruction memory; optional trailing XOR checksum byte    |
// |               enabled by IMEM_LOADER_CHECKSUM_EN.                        |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
module imem_loader #(
    parameter int ADDR_W = 6
) (
    input  wire logic    clk,
    input  wire logic    rst,
    imem_loader_if.slave bus
);

    localparam logic [2:0]  c_ST_LEN_LO = 3'd0;
    localparam logic [2:0]  c_ST_LEN_HI = 3'd1;
    localparam logic [2:0]  c_ST_DATA   = 3'd2;
`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam logic [2:0]  c_ST_CSUM   = 3'd3;
`endif
    localparam logic [2:0]  c_ST_DONE   = 3'd4;
    localparam logic [2:0]  c_ST_ERR    = 3'd5;
    localparam logic [16:0] c_MAX_WORDS = 17'(2 ** ADDR_W);

    logic [2:0]        r_state;
    logic [15:0]       r_len;
    logic [ADDR_W:0]   r_widx;
    logic [1:0]        r_lane;
    logic [23:0]       r_asm;
    logic              r_we;
    logic [ADDR_W-1:0] r_waddr;
    logic [31:0]       r_wdata;
    logic              r_busy;
    logic              r_done;
    logic              r_err;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]        r_csum;
`endif

    logic              w_ready;
    logic [15:0]       w_len_full;
    logic              w_len_bad;
    logic [ADDR_W:0]   w_widx_next;
    logic              w_last_word;

    assign w_ready     = (r_state != c_ST_DONE) && (r_state != c_ST_ERR);
    assign w_len_full  = {bus.in_data, r_len[7:0]};
    assign w_len_bad   = (w_len_full == 16'd0) || ({1'b0, w_len_full} > c_MAX_WORDS);
    // Counter is one bit wider than the address so a full memory does not wrap to 0.
    assign w_widx_next = r_widx + 1'b1;
    assign w_last_word = (16'(w_widx_next) == r_len);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_ST_LEN_LO;
            r_len   <= 16'd0;
            r_widx  <= '0;
            r_lane  <= 2'd0;
            r_asm   <= 24'd0;
            r_we    <= 1'b0;
            r_waddr <= '0;
            r_wdata <= 32'd0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_csum  <= 8'd0;
`endif
        end else begin
            r_we <= 1'b0;
            case (r_state)
                c_ST_LEN_LO: begin
                    if (bus.in_valid) begin
                        r_len[7:0] <= bus.in_data;
                        r_state    <= c_ST_LEN_HI;
                    end
                end
                c_ST_LEN_HI: begin
                    if (bus.in_valid) begin
                        r_len[15:8] <= bus.in_data;
                        if (w_len_bad) begin
                            r_state <= c_ST_ERR;
                            r_err   <= 1'b1;
                        end else begin
                            r_state <= c_ST_DATA;
                            r_busy  <= 1'b1;
                        end
                    end
                end
                c_ST_DATA: begin
                    if (bus.in_valid) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        r_csum <= r_csum ^ bus.in_data;
`endif
                        r_lane <= r_lane + 2'd1;
                        if (r_lane == 2'd3) begin
                            // The fourth byte goes straight into the word, skipping the assembly register.
                            r_we    <= 1'b1;
                            r_wdata <= {bus.in_data, r_asm};
                            r_waddr <= r_widx[ADDR_W-1:0];
                            r_widx  <= w_widx_next;
                            if (w_last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                                r_state <= c_ST_CSUM;
`else
                                r_state <= c_ST_DONE;
                                r_busy  <= 1'b0;
`endif
                            end
                        end else begin
                            r_asm[{r_lane, 3'b000} +: 8] <= bus.in_data;
                        end
                    end
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                c_ST_CSUM: begin
                    if (bus.in_valid) begin
                        r_busy <= 1'b0;
                        if (bus.in_data == r_csum) begin
                            r_state <= c_ST_DONE;
                        end else begin
                            r_state <= c_ST_ERR;
                            r_err   <= 1'b1;
                        end
                    end
                end
`endif
                // done trails the final write by a cycle so fetch never races it.
                c_ST_DONE: r_done <= 1'b1;
                c_ST_ERR:  ;
                default:   ;
            endcase
        end
    end

    assign bus.in_ready = w_ready;
    assign bus.we       = r_we;
    assign bus.waddr    = r_waddr;
    assign bus.wdata    = r_wdata;
    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.err      = r_err;

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_imem_loader                                             |
// | Description : Directed and randomized stream bench for imem_loader.      |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
module tb_imem_loader;

    localparam int ADDR_W = 6;
    localparam int CAP    = 1 << ADDR_W;
`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam bit CSUM_EN = 1'b1;
`else
    localparam bit CSUM_EN = 1'b0;
`endif

    typedef logic [7:0]  byte_q_t[$];
    typedef logic [31:0] word_q_t[$];

    logic clk = 1'b0;
    logic rst = 1'b1;

    imem_loader_if #(.ADDR_W(ADDR_W)) bus ();
    imem_loader #(.ADDR_W(ADDR_W)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Observed writes and timing, collected away from the active edge.
    int          mon_addr[$];
    logic [31:0] mon_data[$];
    int          mon_cyc[$];
    bit          done_seen;
    int          done_cyc;
    int          busy_cnt;

    // Reference expectations.
    int          exp_addr[$];
    logic [31:0] exp_data[$];
    int          exp_we_cyc[$];
    bit          exp_done;
    bit          exp_err;
    int          last_acc;
    int          hdr_acc;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        @(negedge clk);
        if (bus.we === 1'b1) begin
            mon_addr.push_back(int'(bus.waddr));
            mon_data.push_back(bus.wdata);
            mon_cyc.push_back(cyc);
        end
        if (bus.done === 1'b1 && !done_seen) begin
            done_seen = 1'b1;
            done_cyc  = cyc;
        end
        if (bus.busy === 1'b1) busy_cnt++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic byte_q_t build(input word_q_t w, input bit bad_csum);
        byte_q_t    s;
        logic [7:0] x = 8'h00;
        s.push_back(8'(w.size()));
        s.push_back(8'(w.size() >> 8));
        foreach (w[i]) begin
            for (int b = 0; b < 4; b++) begin
                s.push_back(w[i][8*b +: 8]);
                x ^= w[i][8*b +: 8];
            end
        end
        if (CSUM_EN) s.push_back(x ^ {7'd0, bad_csum});
        return s;
    endfunction

    // Expected outcome derived directly from the stream format rules.
    task automatic model(input byte_q_t s);
        int         n;
        logic [7:0] x;
        exp_addr.delete();
        exp_data.delete();
        n = int'({s[1], s[0]});
        if (n == 0 || n > CAP) begin
            exp_err  = 1'b1;
            exp_done = 1'b0;
            return;
        end
        x = 8'h00;
        for (int w = 0; w < n; w++) begin
            exp_addr.push_back(w);
            exp_data.push_back({s[2+4*w+3], s[2+4*w+2], s[2+4*w+1], s[2+4*w]});
            for (int b = 0; b < 4; b++) x ^= s[2+4*w+b];
        end
        if (CSUM_EN) begin
            exp_done = (s.size() > 2 + 4*n) && (s[2+4*n] == x);
            exp_err  = !exp_done;
        end else begin
            exp_done = 1'b1;
            exp_err  = 1'b0;
        end
    endtask

    // mode 0: back-to-back, 1: valid toggles every cycle, 2: random gaps.
    task automatic drive(input byte_q_t s, input int mode, input int n_words);
        int i     = 0;
        bit tog   = 1'b0;
        int stall = 0;
        bit gap;
        while (i < s.size() && stall < 20) begin
            @(negedge clk);
            gap = (mode == 1) ? tog : (mode == 2) ? ($urandom_range(0, 2) == 0) : 1'b0;
            tog = ~tog;
            if (gap) begin
                bus.in_valid = 1'b0;
            end else begin
                bus.in_valid = 1'b1;
                bus.in_data  = s[i];
                if (bus.in_ready === 1'b1) begin
                    if (i >= 2 && i < 2 + 4*n_words && ((i - 2) % 4) == 3)
                        exp_we_cyc.push_back(cyc + 1);
                    if (i == 1) hdr_acc = cyc + 1;
                    last_acc = cyc + 1;
                    i++;
                end else begin
                    stall++;
                end
            end
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_end(input string tag);
        int k;
        for (k = 0; k < 40; k++) begin
            if (bus.done === 1'b1 || bus.err === 1'b1) break;
            @(negedge clk);
        end
        @(negedge clk);
        #1;
        chk({tag, " completion_timeout"}, longint'(k < 40), 1);
    endtask

    task automatic check_run(input string tag);
        chk({tag, " we_count"}, mon_addr.size(), exp_addr.size());
        foreach (exp_addr[i]) begin
            if (i < mon_addr.size()) begin
                chk($sformatf("%s waddr[%0d]", tag, i), mon_addr[i], exp_addr[i]);
                chk($sformatf("%s wdata[%0d]", tag, i), mon_data[i], exp_data[i]);
                if (i < exp_we_cyc.size())
                    chk($sformatf("%s we_latency[%0d]", tag, i), mon_cyc[i], exp_we_cyc[i]);
            end
        end
        chk({tag, " done"}, bus.done, exp_done);
        chk({tag, " err"}, bus.err, exp_err);
        chk({tag, " busy_end"}, bus.busy, 0);
        chk({tag, " in_ready_end"}, bus.in_ready, 0);
        chk({tag, " busy_cycles"}, busy_cnt, (exp_addr.size() > 0) ? last_acc - hdr_acc : 0);
        if (exp_done)
            chk({tag, " done_cycle"}, done_seen ? done_cyc : -1, last_acc + 1);
    endtask

    task automatic check_reset(input string tag);
        chk({tag, " we"}, bus.we, 0);
        chk({tag, " waddr"}, bus.waddr, 0);
        chk({tag, " wdata"}, bus.wdata, 0);
        chk({tag, " busy"}, bus.busy, 0);
        chk({tag, " done"}, bus.done, 0);
        chk({tag, " err"}, bus.err, 0);
        chk({tag, " in_ready"}, bus.in_ready, 1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        mon_addr.delete();
        mon_data.delete();
        mon_cyc.delete();
        exp_we_cyc.delete();
        done_seen = 1'b0;
        busy_cnt  = 0;
        hdr_acc   = 0;
        last_acc  = 0;
        #1;
    endtask

    task automatic run(input byte_q_t s, input int mode, input string tag);
        model(s);
        drive(s, mode, exp_addr.size());
        wait_end(tag);
        check_run(tag);
    endtask

    initial begin
        byte_q_t s;
        word_q_t w;
        int      n_before;
        int      waddr_before;

        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;

        do_reset();
        check_reset("reset");

        // Single word, back-to-back, then bytes offered after completion.
        w = '{32'h00100093};
        s = build(w, 1'b0);
        run(s, 0, "n1");
        if (mon_data.size() > 0) chk("n1 wdata_const", mon_data[0], 32'h00100093);
        n_before     = mon_addr.size();
        waddr_before = int'(bus.waddr);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.in_data  = 8'($urandom);
            chk("after_done in_ready", bus.in_ready, 0);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("after_done we_count", mon_addr.size(), n_before);
        chk("after_done done", bus.done, 1);
        chk("after_done waddr", bus.waddr, waddr_before);

        do_reset();
        w = '{32'h11111111, 32'h22222222, 32'h33333333};
        s = build(w, 1'b0);
        run(s, 1, "n3_toggle");

        do_reset();
        s = '{8'h00, 8'h00};
        run(s, 0, "n0_hdr");

        do_reset();
        s = '{8'h41, 8'h00};
        run(s, 0, "n65_hdr");

        do_reset();
        w.delete();
        for (int i = 0; i < CAP; i++) w.push_back($urandom);
        s = build(w, 1'b0);
        run(s, 2, "n64_full");
        if (mon_addr.size() > 0) chk("n64 last_waddr", mon_addr[mon_addr.size()-1], CAP - 1);

        // Reset mid-load: header, word 0, and half of word 1.
        do_reset();
        w = '{32'h0BADF00D, 32'h12345678};
        s = build(w, 1'b0);
        while (s.size() > 8) void'(s.pop_back());
        drive(s, 0, 2);
        #1;
        chk("midload we_count", mon_addr.size(), 1);
        do_reset();
        check_reset("midload_reset");
        s = '{8'h01, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
        if (CSUM_EN) s.push_back(8'hAA ^ 8'hBB ^ 8'hCC ^ 8'hDD);
        run(s, 0, "after_reset");
        if (mon_data.size() > 0) chk("after_reset wdata_const", mon_data[0], 32'hDDCCBBAA);

        for (int t = 0; t < 4; t++) begin
            do_reset();
            w.delete();
            for (int i = 0, n = $urandom_range(1, 8); i < n; i++) w.push_back($urandom);
            s = build(w, 1'b0);
            run(s, $urandom_range(0, 2), $sformatf("rand%0d", t));
        end

`ifdef IMEM_LOADER_CHECKSUM_EN
        do_reset();
        s = '{8'h01, 8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h0F};
        run(s, 0, "csum_good");
        do_reset();
        s = '{8'h01, 8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h0E};
        run(s, 0, "csum_bad");
        chk("csum_bad write_happened", mon_addr.size(), 1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
